nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: streams W-bit operands one 4-bit slice per cycle
// through an external 4-bit full adder and reassembles the sum.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [IW+1:0] bit_cur;
    logic [IW+1:0] bit_nxt;

    // Bit offsets of the nibble being added now and of the one presented next;
    // the next index is folded to 0 on the last nibble so it never selects out of range.
    always_comb begin
        idx_nxt = (idx == LAST) ? '0 : idx + IW'(1);
        bit_cur = {idx, 2'b00};
        bit_nxt = {idx_nxt, 2'b00};
    end

    // Control FSM and datapath; add_cin doubles as the ripple carry register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            idx       <= '0;
            add_a     <= 4'd0;
            add_b     <= 4'd0;
            add_cin   <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lat    <= op_a;
                        b_lat    <= op_b;
                        idx      <= '0;
                        add_a    <= op_a[3:0];
                        add_b    <= op_b[3:0];
                        add_cin  <= op_cin;
                        cout     <= 1'b0;
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    result[bit_cur +: 4] <= add_sum;
                    idx                  <= idx_nxt;
                    if (idx == LAST) begin
                        cout      <= add_cout;
                        ovf       <= (a_lat[W-1] == b_lat[W-1]) && (add_sum[3] != a_lat[W-1]);
                        add_a     <= 4'd0;
                        add_b     <= 4'd0;
                        add_cin   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        add_a   <= a_lat[bit_nxt +: 4];
                        add_b   <= b_lat[bit_nxt +: 4];
                        add_cin <= add_cout;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    add_a     <= 4'd0;
                    add_b     <= 4'd0;
                    add_cin   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with a behavioural 4-bit adder.
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam int unsigned W1      = W + 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } exp_t;

    exp_t sb[$];

    logic [4:0] add_full;
    assign add_full = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign add_sum  = add_full[3:0];
    assign add_cout = add_full[4];

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t       e;
        logic [W:0] s;
        s     = W1'(a) + W1'(b) + W1'(cin);
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        e.a   = a;
        e.b   = b;
        e.cin = cin;
        return e;
    endfunction

    // Offer one operand set and wait (bounded) for it to be accepted.
    task automatic drive_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                output int waited);
        logic pre;
        waited   = 0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        while (waited < 20) begin
            pre = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (pre) begin
                sb.push_back(model(a, b, cin));
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL accept_timeout: operands a=%h b=%h never accepted in %0d cycles", a, b, waited);
    endtask

    // Follow one operation through RUN, optionally hold in DONE, then consume it.
    task automatic wait_result(input int hold);
        exp_t       e;
        int         n;
        logic       ec;
        logic [4:0] t;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got no pending entry, required one");
            return;
        end
        e  = sb[0];
        ec = e.cin;
        n  = 0;
        while (!out_valid) begin
            if (n < int'(NIBBLES)) begin
                total++;
                if (add_a !== e.a[n*4 +: 4] || add_b !== e.b[n*4 +: 4] || add_cin !== ec) begin
                    bad++;
                    $display("FAIL run_nibble%0d: got a=%h b=%h cin=%b, required a=%h b=%h cin=%b",
                             n, add_a, add_b, add_cin, e.a[n*4 +: 4], e.b[n*4 +: 4], ec);
                end
                t  = 5'(e.a[n*4 +: 4]) + 5'(e.b[n*4 +: 4]) + 5'(ec);
                ec = t[4];
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 30) begin
                total++;
                bad++;
                $display("FAIL result_timeout: out_valid not seen after %0d cycles", n);
                sb.delete(0);
                return;
            end
        end
        total++;
        if (n != int'(NIBBLES)) begin
            bad++;
            $display("FAIL latency: got %0d cycles, required %0d", n, NIBBLES);
        end
        total++;
        if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
            bad++;
            $display("FAIL result: got %h cout=%b ovf=%b, required %h cout=%b ovf=%b",
                     result, cout, ovf, e.res, e.co, e.ov);
        end
        total++;
        if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_idle_outputs: got a=%h b=%h cin=%b in_ready=%b, required 0 0 0 0",
                     add_a, add_b, add_cin, in_ready);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2) == 0;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            op_cin   = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
                bad++;
                $display("FAIL hold%0d: got valid=%b ready=%b res=%h cout=%b ovf=%b, required 1 0 %h %b %b",
                         h, out_valid, in_ready, result, cout, ovf, e.res, e.co, e.ov);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL consume: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        sb.delete(0);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: got ready=%b valid=%b res=%h cout=%b ovf=%b, required 1 0 0 0 0",
                     in_ready, out_valid, result, cout, ovf);
        end
        total++;
        if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
            bad++;
            $display("FAIL reset_adder_port: got a=%h b=%h cin=%b, required 0 0 0", add_a, add_b, add_cin);
        end
    endtask

    task automatic test_first_accept();
        int w;
        rst_n = 1'b1;
        drive_accept(16'h0000, 16'h0000, 1'b0, w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL first_accept: got accept after %0d edges, required 1", w);
        end
        wait_result(0);
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF};
        logic [W-1:0] vb[4] = '{16'h0000, 16'h0001, 16'h0001, 16'hFFFF};
        logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int w;
        for (int i = 0; i < 4; i++) begin
            drive_accept(va[i], vb[i], vc[i], w);
            wait_result(0);
        end
        for (int i = 0; i < 4; i++) begin
            drive_accept(W'($urandom), W'($urandom), 1'($urandom), w);
            wait_result(0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        drive_accept(16'h7FFF, 16'h0001, 1'b0, w);
        wait_result(10);
        drive_accept(16'h8000, 16'h8000, 1'b0, w);
        wait_result(3);
    endtask

    task automatic test_reset_mid_run();
        int w;
        drive_accept(16'h1111, 16'h2222, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || add_a !== 4'd0 || add_cin !== 1'b0) begin
            bad++;
            $display("FAIL mid_run_reset: got ready=%b valid=%b res=%h a=%h cin=%b, required 1 0 0 0 0",
                     in_ready, out_valid, result, add_a, add_cin);
        end
        rst_n = 1'b1;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        drive_accept(16'h1234, 16'h4321, 1'b0, w);
        wait_result(0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hA5A5};
        logic [W-1:0] tb[4] = '{16'h4321, 16'h0001, 16'h0001, 16'h5A5A};
        logic         tc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   i        = 0;
        int   got      = 0;
        int   cyc      = 0;
        int   last_acc = -1;
        logic pre;
        exp_t e;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op_a      = ta[0];
        op_b      = tb[0];
        op_cin    = tc[0];
        while (got < 4 && cyc < 60) begin
            pre = in_ready & in_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (pre) begin
                sb.push_back(model(ta[i], tb[i], tc[i]));
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != int'(NIBBLES) + 2) begin
                        bad++;
                        $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - last_acc, NIBBLES + 2);
                    end
                end
                last_acc = cyc;
                i++;
                if (i < 4) begin
                    op_a   = ta[i];
                    op_b   = tb[i];
                    op_cin = tc[i];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected: got result %h, required none pending", result);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
                        bad++;
                        $display("FAIL b2b_result%0d: got %h cout=%b ovf=%b, required %h cout=%b ovf=%b",
                                 got, result, cout, ovf, e.res, e.co, e.ov);
                    end
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d results, required 4", got);
        end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
